// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin arbiter sharing one data-memory port between cores
module dm_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_LAT   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        grant,
    output logic [NUM_CORES-1:0]        done,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);
    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NUM_CORES - 1);
    localparam logic [PTR_W:0]   NUM_EXT  = (PTR_W+1)'(NUM_CORES);
    localparam logic [NUM_CORES-1:0] ONE_HOT0 = {{(NUM_CORES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       idx_q, idx_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CORES-1:0]   grant_q, grant_d;
    logic [NUM_CORES-1:0]   done_q, done_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   mem_en_q, mem_en_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;

    logic [ADDR_W-1:0]      addr_a  [NUM_CORES];
    logic [DATA_W-1:0]      wdata_a [NUM_CORES];
    logic [PTR_W-1:0]       win;
    logic                   win_vld;
    logic [PTR_W:0]         cand;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
            wdata_a[i] = wdata[i*DATA_W +: DATA_W];
        end
    end

    // Scan from the farthest offset back to ptr so the nearest requester wins last.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(j);
            if (cand >= NUM_EXT) begin
                cand = cand - NUM_EXT;
            end
            if (req[cand[PTR_W-1:0]]) begin
                win     = cand[PTR_W-1:0];
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        done_d      = done_q;
        rdata_d     = rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d     = S_BUSY;
                    idx_d       = win;
                    grant_d     = ONE_HOT0 << win;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we[win];
                    mem_addr_d  = addr_a[win];
                    mem_wdata_d = wdata_a[win];
                    cnt_d       = '0;
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    done_d   = ONE_HOT0 << idx_q;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                grant_d = '0;
                done_d  = '0;
                ptr_d   = (idx_q == PTR_MAX) ? '0 : idx_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter against a transaction-level model
module tb_dm_arbiter;
    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we  = '0;
    logic [N*AW-1:0] addr  = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    grant, done;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [N-1:0] drop_on_done = '0;
    int done_core[$];
    int done_cyc[$];

    dm_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .grant(grant), .done(done), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return 16'(a * 16'h9E37 + 16'h1234);
    endfunction

    assign mem_rdata = rd_fn(mem_addr);

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int j = 0; j < N; j++) if (r[(p + j) % N]) return (p + j) % N;
        return 0;
    endfunction

    function automatic logic [AW-1:0] a_of(input logic [N*AW-1:0] v, input int i);
        return v[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] d_of(input logic [N*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40) $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Transaction model: m_age counts cycles since grant (0 = no transaction).
    int            m_age, m_ptr, m_core;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_age <= 0; m_ptr <= 0; m_core <= 0; m_we <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
        end else if (m_age == 0) begin
            if (req != '0) begin
                m_core  <= pick(req, m_ptr);
                m_we    <= we[pick(req, m_ptr)];
                m_addr  <= a_of(addr, pick(req, m_ptr));
                m_wdata <= d_of(wdata, pick(req, m_ptr));
                m_age   <= 1;
            end
        end else if (m_age == LAT + 1) begin
            m_age <= 0;
            m_ptr <= (m_core + 1) % N;
        end else begin
            if (m_age == LAT && !m_we) m_rdata <= rd_fn(m_addr);
            m_age <= m_age + 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        chk("grant", 32'(grant), (m_age != 0) ? (32'd1 << m_core) : 32'd0);
        chk("done", 32'(done), (m_age == LAT + 1) ? (32'd1 << m_core) : 32'd0);
        chk("mem_en", 32'(mem_en), 32'(m_age >= 1 && m_age <= LAT));
        chk("mem_we", 32'(mem_we), 32'(m_age >= 1 && m_age <= LAT && m_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        chk("rdata", 32'(rdata), 32'(m_rdata));
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                done_core.push_back(i);
                done_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) if (done[i] && drop_on_done[i]) req[i] = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_core(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i] = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;

        // single read by core 0
        do_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        drop_on_done = '1;
        set_core(0, 1'b0, 16'h0010, 16'h0000);
        req = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t1_grant", 32'(grant), (k <= 3) ? 32'd1 : 32'd0);
            chk("t1_mem_en", 32'(mem_en), (k <= 2) ? 32'd1 : 32'd0);
            chk("t1_done", 32'(done), (k == 3) ? 32'd1 : 32'd0);
            if (k >= 3) chk("t1_rdata", 32'(rdata), 32'hBEEF);
        end

        // all four cores together after reset
        do_reset();
        for (int i = 0; i < N; i++) set_core(i, 1'b0, 16'(16'h0100 + i), 16'h0);
        done_core.delete(); done_cyc.delete();
        req = 4'b1111;
        t0 = cyc;
        run(18);
        chk("t2_count", 32'(done_core.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", 32'(done_core[i]), 32'(i));
            chk("t2_done_cyc", 32'(done_cyc[i] - t0), 32'(3 + 4 * i));
        end

        // cores 0 and 2 continuous
        done_core.delete(); done_cyc.delete();
        drop_on_done = '0;
        req = 4'b0101;
        run(17);
        req = '0;
        run(6);
        chk("t3_first", 32'(done_core[0]), 32'd0);
        chk("t3_enough", 32'(done_core.size() >= 4), 32'd1);
        for (int i = 1; i < done_core.size(); i++)
            chk("t3_alternate", 32'(done_core[i]), (done_core[i-1] == 0) ? 32'd2 : 32'd0);

        // write after read leaves rdata untouched
        drop_on_done = '1;
        set_core(0, 1'b0, 16'h0010, 16'h0);
        req = 4'b0001;
        run(6);
        set_core(1, 1'b1, 16'h00FF, 16'h1234);
        req = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k <= 2) begin
                chk("t4_mem_we", 32'(mem_we), 32'd1);
                chk("t4_mem_addr", 32'(mem_addr), 32'h00FF);
                chk("t4_mem_wdata", 32'(mem_wdata), 32'h1234);
            end
            chk("t4_rdata", 32'(rdata), 32'hBEEF);
        end
        run(2);

        // wrap: core 2 leaves ptr=3, then cores 0 and 3 together
        set_core(2, 1'b0, 16'h0200, 16'h0);
        set_core(3, 1'b0, 16'h0300, 16'h0);
        req = 4'b0100;
        run(6);
        done_core.delete(); done_cyc.delete();
        req = 4'b1001;
        run(10);
        chk("t5_count", 32'(done_core.size()), 32'd2);
        chk("t5_first", 32'(done_core[0]), 32'd3);
        chk("t5_second", 32'(done_core[1]), 32'd0);

        // reset in the middle of a read
        set_core(2, 1'b0, 16'h0040, 16'h0);
        req = 4'b0100;
        run(2);
        rst = 1'b1;
        req = '0;
        #1;
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_mem_en", 32'(mem_en), 32'd0);
        chk("t6_mem_we", 32'(mem_we), 32'd0);
        chk("t6_mem_addr", 32'(mem_addr), 32'd0);
        chk("t6_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("t6_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_core.delete(); done_cyc.delete();
        run(5);
        chk("t6_no_done", 32'(done_core.size()), 32'd0);
        req = 4'b0011;
        run(10);
        chk("t6_count", 32'(done_core.size()), 32'd2);
        chk("t6_first", 32'(done_core[0]), 32'd0);
        chk("t6_second", 32'(done_core[1]), 32'd1);

        // randomized traffic, including occasional resets
        drop_on_done = '0;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                req[i] = ($urandom_range(0, 3) == 0);
                set_core(i, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            end
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        req = '0;
        run(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
